// File: rtl/fwrisc_wb_pkg.sv
// Shared types for the fwrisc writeback stage.
package fwrisc_wb_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    ALU  = 3'd1,
    LB   = 3'd2,
    LH   = 3'd3,
    LW   = 3'd4,
    LBU  = 3'd5,
    LHU  = 3'd6
  } wb_op_t;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  // True for any op that must wait for a data-memory response.
  function automatic logic is_load(input wb_op_t op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

endpackage

// File: rtl/fwrisc_wb_load_align.sv
// Combinational load aligner: selects the addressed byte/halfword of an
// aligned memory word and sign- or zero-extends it to 32 bits.
module fwrisc_load_align
  import fwrisc_wb_pkg::*;
(
  input  wb_op_t      i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and extension by load type; LW passes the word through.
  always_comb begin
    w_byte = i_rdata[8*i_addr_lo +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = i_rdata;
    case (i_op)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_data = {24'h0, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LHU:     o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/fwrisc_wb.sv
// fwrisc writeback stage: retires ALU/NONE ops one cycle after accept and
// loads one cycle after the data-memory response; drives the regfile port.
module fwrisc_wb
  import fwrisc_wb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ex_valid,
  output logic                        ex_ready,
  input  logic [2:0]                  ex_op,
  input  logic [$clog2(NUM_REGS)-1:0] ex_rd,
  input  logic [31:0]                 ex_result,
  input  logic [1:0]                  ex_addr_lo,
  input  logic                        dmem_rvalid,
  input  logic [31:0]                 dmem_rdata,
  output logic [$clog2(NUM_REGS)-1:0] rd_waddr,
  output logic [31:0]                 rd_wdata,
  output logic                        rd_wen,
  output logic                        instr_complete,
  output logic                        ld_pending,
  output logic [$clog2(NUM_REGS)-1:0] ld_pending_rd
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  wb_state_t   r_state,      w_state_nxt;
  wb_op_t      r_ld_op,      w_ld_op_nxt;
  logic [1:0]  r_ld_lo,      w_ld_lo_nxt;
  logic [AW-1:0] r_ld_rd,    w_ld_rd_nxt;
  logic        r_ld_pending, w_ld_pending_nxt;
  logic        r_ex_ready,   w_ex_ready_nxt;
  logic        r_wen,        w_wen_nxt;
  logic        r_complete,   w_complete_nxt;
  logic [AW-1:0] r_waddr,    w_waddr_nxt;
  logic [31:0] r_wdata,      w_wdata_nxt;

  wb_op_t      w_op;
  logic [31:0] w_aligned;

  assign w_op = wb_op_t'(ex_op);

  fwrisc_load_align u_align (
    .i_op      (r_ld_op),
    .i_addr_lo (r_ld_lo),
    .i_rdata   (dmem_rdata),
    .o_data    (w_aligned)
  );

  // State and registered outputs; reset drops any outstanding load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ld_op      <= NONE;
      r_ld_lo      <= '0;
      r_ld_rd      <= '0;
      r_ld_pending <= 1'b0;
      r_ex_ready   <= 1'b1;
      r_wen        <= 1'b0;
      r_complete   <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ld_op      <= w_ld_op_nxt;
      r_ld_lo      <= w_ld_lo_nxt;
      r_ld_rd      <= w_ld_rd_nxt;
      r_ld_pending <= w_ld_pending_nxt;
      r_ex_ready   <= w_ex_ready_nxt;
      r_wen        <= w_wen_nxt;
      r_complete   <= w_complete_nxt;
      r_waddr      <= w_waddr_nxt;
      r_wdata      <= w_wdata_nxt;
    end
  end

  // Next-state and next-output decode; write/complete strobes default low.
  always_comb begin
    w_state_nxt      = r_state;
    w_ld_op_nxt      = r_ld_op;
    w_ld_lo_nxt      = r_ld_lo;
    w_ld_rd_nxt      = r_ld_rd;
    w_ld_pending_nxt = r_ld_pending;
    w_wen_nxt        = 1'b0;
    w_complete_nxt   = 1'b0;
    w_waddr_nxt      = r_waddr;
    w_wdata_nxt      = r_wdata;
    case (r_state)
      IDLE: begin
        if (ex_valid) begin
          if (w_op == ALU) begin
            w_wen_nxt      = (ex_rd != '0);
            w_waddr_nxt    = ex_rd;
            w_wdata_nxt    = ex_result;
            w_complete_nxt = 1'b1;
          end else if (is_load(w_op)) begin
            w_ld_op_nxt      = w_op;
            w_ld_lo_nxt      = ex_addr_lo;
            w_ld_rd_nxt      = ex_rd;
            w_ld_pending_nxt = 1'b1;
            w_state_nxt      = WAIT_LOAD;
          end else begin
            w_complete_nxt = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          w_wen_nxt        = (r_ld_rd != '0);
          w_waddr_nxt      = r_ld_rd;
          w_wdata_nxt      = w_aligned;
          w_complete_nxt   = 1'b1;
          w_ld_pending_nxt = 1'b0;
          w_state_nxt      = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ex_ready is registered off the next state so it is high exactly in IDLE.
  assign w_ex_ready_nxt = (w_state_nxt == IDLE);

  assign ex_ready       = r_ex_ready;
  assign rd_wen         = r_wen;
  assign rd_waddr       = r_waddr;
  assign rd_wdata       = r_wdata;
  assign instr_complete = r_complete;
  assign ld_pending     = r_ld_pending;
  assign ld_pending_rd  = r_ld_rd;

endmodule

// File: tb/tb_fwrisc_wb.sv
// Randomized self-checking bench for fwrisc_wb against a behavioural model.
module tb_fwrisc_wb;
  import fwrisc_wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [2:0]  ex_op = 3'd0;
  logic [5:0]  ex_rd = 6'd0;
  logic [31:0] ex_result = 32'd0;
  logic [1:0]  ex_addr_lo = 2'd0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_wen;
  logic        instr_complete;
  logic        ld_pending;
  logic [5:0]  ld_pending_rd;

  int total = 0;
  int bad = 0;

  fwrisc_wb #(.NUM_REGS(64)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_result(ex_result), .ex_addr_lo(ex_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .rd_wen(rd_wen), .instr_complete(instr_complete),
    .ld_pending(ld_pending), .ld_pending_rd(ld_pending_rd)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: value a load of this type/offset returns, computed arithmetically.
  function automatic logic [31:0] exp_load(input wb_op_t op, input logic [1:0] lo,
                                           input logic [31:0] d);
    int v;
    case (op)
      LB, LBU: begin
        v = int'((d >> (8 * lo)) & 32'hFF);
        if (op == LB && v >= 128) v = v - 256;
      end
      LH, LHU: begin
        v = int'((d >> (16 * (lo / 2))) & 32'hFFFF);
        if (op == LH && v >= 32768) v = v - 65536;
      end
      default: v = int'(d);
    endcase
    return 32'(v);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++;
    if ({rd_wen, instr_complete, rd_waddr, rd_wdata, ld_pending, ld_pending_rd, ex_ready}
        !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got wen=%b cmp=%b wa=%0d wd=%h lp=%b lprd=%0d rdy=%b, want 0 0 0 0 0 0 1",
               rd_wen, instr_complete, rd_waddr, rd_wdata, ld_pending, ld_pending_rd, ex_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  // Issue one ALU op and check its single-cycle writeback.
  task automatic do_alu(input logic [5:0] rd, input logic [31:0] res, input bit drop_after,
                        input string name);
    total++;
    if (ex_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: got %b want 1", name, ex_ready);
    end
    ex_valid = 1'b1; ex_op = 3'(ALU); ex_rd = rd; ex_result = res;
    tick();
    total++;
    if ({rd_wen, instr_complete, rd_waddr, rd_wdata} !== {(rd != 6'd0), 1'b1, rd, res}) begin
      bad++;
      $display("FAIL %s_write: got wen=%b cmp=%b wa=%0d wd=%h want wen=%b cmp=1 wa=%0d wd=%h",
               name, rd_wen, instr_complete, rd_waddr, rd_wdata, (rd != 6'd0), rd, res);
    end
    if (drop_after) begin
      ex_valid = 1'b0;
      tick();
      total++;
      if ({rd_wen, instr_complete} !== 2'b00) begin
        bad++;
        $display("FAIL %s_after: got wen=%b cmp=%b want 0 0", name, rd_wen, instr_complete);
      end
    end
  endtask

  task automatic test_alu();
    do_alu(6'd5, 32'hDEADBEEF, 1'b1, "alu_r5");
    do_alu(6'd0, 32'h00001234, 1'b1, "alu_r0");
    for (int i = 0; i < 20; i++)
      do_alu(6'($urandom_range(0, 63)), $urandom, 1'b1, "alu_rand");
    // NONE retires with no write.
    ex_valid = 1'b1; ex_op = 3'(NONE); ex_rd = 6'd9;
    tick();
    ex_valid = 1'b0;
    total++;
    if ({rd_wen, instr_complete} !== 2'b01) begin
      bad++;
      $display("FAIL none_op: got wen=%b cmp=%b want 0 1", rd_wen, instr_complete);
    end
    tick();
  endtask

  // Issue a load, hold execute's request during the wait, respond after dly cycles.
  task automatic do_load(input wb_op_t op, input logic [5:0] rd, input logic [1:0] lo,
                         input logic [31:0] data, input int dly, input string name);
    logic [31:0] want;
    want = exp_load(op, lo, data);
    ex_valid = 1'b1; ex_op = 3'(op); ex_rd = rd; ex_addr_lo = lo; ex_result = $urandom;
    tick();
    for (int c = 0; c < dly; c++) begin
      total++;
      if ({ld_pending, ld_pending_rd, ex_ready, rd_wen, instr_complete} !== {1'b1, rd, 3'b000}) begin
        bad++;
        $display("FAIL %s_wait: got lp=%b lprd=%0d rdy=%b wen=%b cmp=%b want 1 %0d 0 0 0",
                 name, ld_pending, ld_pending_rd, ex_ready, rd_wen, instr_complete, rd);
      end
      if (c == dly - 1) begin
        ex_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = data;
      end
      tick();
    end
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    total++;
    if ({rd_wen, instr_complete, rd_waddr, rd_wdata, ld_pending, ex_ready}
        !== {(rd != 6'd0), 1'b1, rd, want, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL %s_write: got wen=%b cmp=%b wa=%0d wd=%h lp=%b rdy=%b want wen=%b cmp=1 wa=%0d wd=%h lp=0 rdy=1",
               name, rd_wen, instr_complete, rd_waddr, rd_wdata, ld_pending, ex_ready,
               (rd != 6'd0), rd, want);
    end
    tick();
    total++;
    if ({rd_wen, instr_complete} !== 2'b00) begin
      bad++;
      $display("FAIL %s_after: got wen=%b cmp=%b want 0 0", name, rd_wen, instr_complete);
    end
  endtask

  task automatic test_loads();
    wb_op_t ops [5] = '{LB, LH, LW, LBU, LHU};
    do_load(LB,  6'd7,  2'd3, 32'h80FF0000, 3, "ld_lb");
    do_load(LHU, 6'd12, 2'd2, 32'h9ABC1234, 1, "ld_lhu");
    do_load(LH,  6'd13, 2'd0, 32'h00008001, 2, "ld_lh");
    do_load(LW,  6'd14, 2'd1, 32'h11223344, 1, "ld_lw");
    do_load(LBU, 6'd0,  2'd1, 32'h0000FF00, 2, "ld_r0");
    for (int i = 0; i < 30; i++)
      do_load(ops[$urandom_range(0, 4)], 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
              $urandom, int'($urandom_range(1, 4)), "ld_rand");
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [5:0] rds [4];
    logic [31:0] vals [4];
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_rvalid = 1'b0;
    total++;
    if ({rd_wen, instr_complete, ld_pending, ex_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL stray_rvalid: got wen=%b cmp=%b lp=%b rdy=%b want 0 0 0 1",
               rd_wen, instr_complete, ld_pending, ex_ready);
    end
    for (int i = 0; i < 4; i++) begin
      rds[i] = 6'($urandom_range(1, 63));
      vals[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      do_alu(rds[i], vals[i], 1'b0, "b2b");
      if (instr_complete === 1'b1) pulses++;
    end
    ex_valid = 1'b0;
    tick();
    if (instr_complete === 1'b1) pulses++;
    total++;
    if (pulses !== 4) begin
      bad++;
      $display("FAIL b2b_pulses: got %0d want 4", pulses);
    end
  endtask

  task automatic test_reset_mid_load();
    ex_valid = 1'b1; ex_op = 3'(LW); ex_rd = 6'd9; ex_addr_lo = 2'd0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ({rd_wen, instr_complete, rd_waddr, rd_wdata, ld_pending, ld_pending_rd, ex_ready}
        !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1}) begin
      bad++;
      $display("FAIL midload_reset: got wen=%b cmp=%b wa=%0d wd=%h lp=%b lprd=%0d rdy=%b want 0 0 0 0 0 0 1",
               rd_wen, instr_complete, rd_waddr, rd_wdata, ld_pending, ld_pending_rd, ex_ready);
    end
    ex_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
    tick();
    dmem_rvalid = 1'b0;
    total++;
    if ({rd_wen, instr_complete, ld_pending, ex_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL midload_drop: got wen=%b cmp=%b lp=%b rdy=%b want 0 0 0 1",
               rd_wen, instr_complete, ld_pending, ex_ready);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_back_to_back();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwrisc_wb.md
# fwrisc_wb

Writeback stage for the fwrisc core; it sits directly upstream of the register file and drives its write port and its instruction-completion strobe. It accepts completed operations from execute over a valid/ready handshake. ALU results are written back immediately. Loads wait for the data-memory response, which is byte/halfword-aligned and sign- or zero-extended before it is written.

## Interface
Parameters:
- `NUM_REGS`, default 64: register address space; the address width is 6.

Ports:
- `clock`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  execute presents an operation
- `ex_ready`  out  1  writeback can accept an operation
- `ex_op`  in  3  writeback op (`wb_op_t`): ALU, LB, LH, LW, LBU, LHU, NONE
- `ex_rd`  in  6  destination register address
- `ex_result`  in  32  ALU result (ALU op only)
- `ex_addr_lo`  in  2  low bits of the load address
- `dmem_rvalid`  in  1  load data valid (single-cycle pulse)
- `dmem_rdata`  in  32  load data, full aligned word
- `rd_waddr`  out  6  register-file write address
- `rd_wdata`  out  32  register-file write data
- `rd_wen`  out  1  register-file write enable
- `instr_complete`  out  1  one-cycle pulse per retired operation
- `ld_pending`  out  1  a load is outstanding
- `ld_pending_rd`  out  6  destination of the outstanding load (hazard check)

## Operation
- States: IDLE and WAIT_LOAD.
- `ex_ready` = (state == IDLE). An operation is accepted when `ex_valid && ex_ready`.
- IDLE, accept with ALU: next cycle `rd_wen`=(`ex_rd` != 0), `rd_waddr`=`ex_rd`, `rd_wdata`=`ex_result`, `instr_complete`=1. State stays IDLE.
- IDLE, accept with NONE (stores, branches): next cycle `instr_complete`=1 and `rd_wen`=0.
- IDLE, accept with a load: latch rd, op and addr_lo; go to WAIT_LOAD. `ld_pending`=1 and `ld_pending_rd`=rd from the next cycle.
- WAIT_LOAD, `dmem_rvalid`: next cycle write the aligned data and pulse `instr_complete`; go to IDLE; `ld_pending` drops in that same cycle.
- Load alignment:
  - LB/LBU select byte `addr_lo`.
  - LH/LHU select halfword `addr_lo[1]`; `addr_lo[0]` is ignored.
  - LW uses the full word; `addr_lo` is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- rd = 0: writes are always suppressed (`rd_wen`=0), but `instr_complete` still pulses.
- `dmem_rvalid` while IDLE is ignored; no state change and no write.
- `ex_valid` while in WAIT_LOAD is not accepted; execute holds its inputs stable.
- `rd_wen` and `instr_complete` are high for exactly one cycle per retired operation.

## Timing
- All outputs are registered.
- Reset values: `rd_wen`=0, `instr_complete`=0, `rd_waddr`=0, `rd_wdata`=0, `ld_pending`=0, `ld_pending_rd`=0; state = IDLE.
- ALU/NONE latency: accept at cycle N, write and complete at N+1.
  - Back-to-back ALU ops give one writeback every cycle.
- Load latency: accept at N, response at M ≥ N+1, write at M+1. `ex_ready` returns high at M+1, so the next accept is at M+1 at the earliest.
- The register file commits the write on the edge ending cycle M+1 (or N+1). Read-after-write forwarding is execute's responsibility; it uses `ld_pending`/`ld_pending_rd` and the `rd_*` outputs.
- Reset asserted mid-load: all outputs and state clear immediately. The outstanding response is dropped, with no write and no `instr_complete`.

## Structure
- `fwrisc_wb_pkg` holds:
  - `wb_op_t` enum: NONE=0, ALU=1, LB=2, LH=3, LW=4, LBU=5, LHU=6.
  - `wb_state_t` enum: IDLE, WAIT_LOAD.
- Sub-module `fwrisc_load_align` (combinational): inputs op, addr_lo, rdata; output is the extended 32-bit value. It is reused by the formal harness.

## Test plan
- ALU op, rd=5, result 0xDEADBEEF accepted at cycle 10 -> cycle 11: `rd_wen`=1, `rd_waddr`=5, `rd_wdata`=0xDEADBEEF, `instr_complete`=1. Cycle 12: both low.
- ALU op with rd=0, result 0x1234 -> `rd_wen`=0, `instr_complete`=1.
- LB, rd=7, addr_lo=3, rdata 0x80FF_0000 arriving 3 cycles after accept -> `rd_wdata`=0xFFFFFF80. `ld_pending`=1 with `ld_pending_rd`=7 throughout the wait; `ex_ready`=0 during the wait.
- LHU with addr_lo=2 and rdata 0x9ABC_1234 -> 0x00009ABC. LH with addr_lo=0 and rdata 0x0000_8001 -> 0xFFFF8001. LW with addr_lo=1 and rdata 0x11223344 -> 0x11223344.
- Stray `dmem_rvalid` in IDLE, then 4 back-to-back ALU ops -> no spurious write; exactly 4 consecutive `instr_complete` pulses.
- Reset asserted 1 cycle into WAIT_LOAD, `dmem_rvalid` arriving after reset deasserts -> no write, no `instr_complete`, `ld_pending`=0, `ex_ready`=1.
